// File: rtl/x_input_streamer.sv
// x_input_streamer: buffers MATRIX_NUM matrices of 32 bytes written over a host
// byte port, then on `go` feeds them to the matrix core one matrix at a time
// using the start_in / valid_input / X_load protocol. Between matrices it waits
// for a rising edge of the core's `finish` and inserts GAP_CYCLES idle cycles.
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   wr_en, wr_data  host byte write; wr_ready says a write is accepted this cycle
//   clr             clear the buffer (IDLE only)
//   go              start a run (IDLE with a full buffer only)
//   full, busy      buffer full / run in progress
//   done            one-cycle pulse at run completion
//   matrix_idx      index of the matrix currently being sent
//   start_in        to core: one-cycle pulse before each matrix
//   valid_input     to core: high for 32 cycles per matrix
//   X_load          to core: current byte, 0 when valid_input is low
//   finish          from core: end-of-matrix level
module x_input_streamer #(
  parameter int MATRIX_NUM = 2,
  parameter int GAP_CYCLES = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  output logic                        wr_ready,
  input  logic                        clr,
  input  logic                        go,
  output logic                        full,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(MATRIX_NUM):0] matrix_idx,
  output logic                        start_in,
  output logic                        valid_input,
  output logic [7:0]                  X_load,
  input  logic                        finish
);

  localparam int unsigned TOTAL    = MATRIX_NUM * 32;
  localparam int unsigned AW       = $clog2(TOTAL);
  localparam int unsigned PW       = AW + 1;
  localparam int unsigned MW       = $clog2(MATRIX_NUM) + 1;
  localparam int unsigned GW       = $clog2(GAP_CYCLES + 1) + 1;
  localparam int unsigned M_LAST   = MATRIX_NUM - 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_STREAM   = 3'd2;
  localparam logic [2:0] S_WAIT_FIN = 3'd3;
  localparam logic [2:0] S_GAP      = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] ridx_q, ridx_d;
  logic [MW-1:0] midx_q, midx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          finish_d_q;
  logic          full_q, full_d;
  logic          wr_ready_q, wr_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          start_q, start_d;
  logic          valid_q, valid_d;
  logic          wr_accept;
  logic          fin_rise;

  logic [7:0]    mem_q [TOTAL];

  // Next-state, pointer and output-flop logic
  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    ridx_d    = ridx_q;
    midx_d    = midx_q;
    gap_d     = gap_q;
    wr_accept = 1'b0;
    fin_rise  = finish && !finish_d_q;

    case (state_q)
      S_IDLE: begin
        // clr beats go and writes; go (only possible when full) beats writes
        if (clr) begin
          wptr_d = '0;
        end else if (go && full_q) begin
          state_d = S_START;
          ridx_d  = '0;
          midx_d  = '0;
        end else if (wr_en && !full_q) begin
          wr_accept = 1'b1;
          wptr_d    = wptr_q + PW'(1);
        end
      end
      S_START: state_d = S_STREAM;
      S_STREAM: begin
        ridx_d = ridx_q + AW'(1);
        if (ridx_q[4:0] == 5'd31) state_d = S_WAIT_FIN;
      end
      S_WAIT_FIN: begin
        if (fin_rise) begin
          if (midx_q == MW'(M_LAST)) begin
            state_d = S_DONE;
          end else begin
            midx_d  = midx_q + MW'(1);
            gap_d   = '0;
            state_d = (GAP_CYCLES == 0) ? S_START : S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GW'(GAP_LAST)) state_d = S_START;
        else                        gap_d   = gap_q + GW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    full_d     = (wptr_d == PW'(TOTAL));
    wr_ready_d = (state_d == S_IDLE) && !full_d;
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    start_d    = (state_d == S_START);
    valid_d    = (state_d == S_STREAM);
  end

  // State and control registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      ridx_q     <= '0;
      midx_q     <= '0;
      gap_q      <= '0;
      finish_d_q <= 1'b0;
      full_q     <= 1'b0;
      wr_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      start_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      ridx_q     <= ridx_d;
      midx_q     <= midx_d;
      gap_q      <= gap_d;
      finish_d_q <= finish;
      full_q     <= full_d;
      wr_ready_q <= wr_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      start_q    <= start_d;
      valid_q    <= valid_d;
    end
  end

  // Byte buffer; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (rst && wr_accept) mem_q[wptr_q[AW-1:0]] <= wr_data;
  end

  assign wr_ready    = wr_ready_q;
  assign full        = full_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign matrix_idx  = midx_q;
  assign start_in    = start_q;
  assign valid_input = valid_q;
  // Combinational read from the registered index, forced to 0 outside STREAM
  assign X_load      = valid_q ? mem_q[ridx_q] : 8'h00;

endmodule

// File: tb/tb_x_input_streamer.sv
// Self-checking bench for x_input_streamer: a default instance (GAP_CYCLES=3)
// and a zero-gap instance share all inputs; streamed bytes are checked against
// per-instance expected-byte queues.
module tb_x_input_streamer;

  localparam int TOT = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       clr = 1'b0;
  logic       go = 1'b0;
  logic       finish = 1'b0;

  logic       wr_ready, full, busy, done, start_in, valid_input;
  logic [1:0] matrix_idx;
  logic [7:0] X_load;
  logic       z_wr_ready, z_full, z_busy, z_done, z_start_in, z_valid_input;
  logic [1:0] z_matrix_idx;
  logic [7:0] z_X_load;

  x_input_streamer #(.MATRIX_NUM(2), .GAP_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
    .clr(clr), .go(go), .full(full), .busy(busy), .done(done),
    .matrix_idx(matrix_idx), .start_in(start_in), .valid_input(valid_input),
    .X_load(X_load), .finish(finish)
  );

  x_input_streamer #(.MATRIX_NUM(2), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_ready(z_wr_ready),
    .clr(clr), .go(go), .full(z_full), .busy(z_busy), .done(z_done),
    .matrix_idx(z_matrix_idx), .start_in(z_start_in), .valid_input(z_valid_input),
    .X_load(z_X_load), .finish(finish)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] model [TOT];
  int         m_wptr = 0;
  logic [7:0] exp_q[$];
  logic [7:0] zexp_q[$];

  // Scoreboard: every valid cycle pops and compares one expected byte
  always @(negedge clk) begin : mon
    logic [7:0] e;
    if (valid_input) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL stream_extra got %02h with no byte expected", X_load);
      end else begin
        e = exp_q.pop_front();
        if (X_load !== e) begin
          n_fail++;
          $display("FAIL stream_byte got %02h want %02h", X_load, e);
        end
      end
    end
    if (z_valid_input) begin
      n_tests++;
      if (zexp_q.size() == 0) begin
        n_fail++;
        $display("FAIL z_stream_extra got %02h with no byte expected", z_X_load);
      end else begin
        e = zexp_q.pop_front();
        if (z_X_load !== e) begin
          n_fail++;
          $display("FAIL z_stream_byte got %02h want %02h", z_X_load, e);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0; wr_en = 1'b0; clr = 1'b0; go = 1'b0; finish = 1'b0;
    tick; tick;
    rst = 1'b1;
    m_wptr = 0;
    exp_q.delete();
    zexp_q.delete();
  endtask

  task automatic write_bytes(input logic [7:0] base, input logic [7:0] step, input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'(int'(base) + int'(step) * i);
      wr_en = 1'b1; wr_data = b;
      if (m_wptr < TOT) begin
        model[m_wptr] = b;
        m_wptr++;
      end
      tick;
    end
    wr_en = 1'b0;
  endtask

  task automatic push_run;
    for (int i = 0; i < TOT; i++) begin
      exp_q.push_back(model[i]);
      zexp_q.push_back(model[i]);
    end
  endtask

  // Counts consecutive valid cycles starting with the current one (bounded)
  task automatic wait_stream(output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (!valid_input) break;
      n++;
      tick;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick; tick;
    n_tests++;
    if ({start_in, valid_input, busy, done, full} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got %05b want 00000", {start_in, valid_input, busy, done, full});
    end
    n_tests++;
    if ({X_load, matrix_idx} !== 10'h0) begin
      n_fail++;
      $display("FAIL reset_data got X_load=%02h idx=%0d want 0/0", X_load, matrix_idx);
    end
    rst = 1'b1;
    tick;
    n_tests++;
    if (wr_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release got wr_ready=%b busy=%b want 1/0", wr_ready, busy);
    end
  endtask

  task automatic test_basic;
    int n;
    do_reset;
    write_bytes(8'h00, 8'h01, 64);
    n_tests++;
    if (full !== 1'b1 || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_full got full=%b wr_ready=%b want 1/0", full, wr_ready);
    end
    push_run;
    go = 1'b1;
    tick;                               // N+1
    go = 1'b0;
    n_tests++;
    if (start_in !== 1'b1 || busy !== 1'b1 || z_start_in !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_start got start=%b busy=%b zstart=%b want 1/1/1", start_in, busy, z_start_in);
    end
    tick;                               // N+2
    n_tests++;
    if (start_in !== 1'b0 || matrix_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL basic_stream0 got start=%b idx=%0d want 0/0", start_in, matrix_idx);
    end
    wait_stream(n);                     // ends at N+34
    n_tests++;
    if (n !== 32) begin
      n_fail++;
      $display("FAIL basic_len0 got %0d want 32", n);
    end
    tick; tick; tick; tick;             // N+38
    finish = 1'b1;
    tick;                               // F+1
    finish = 1'b0;
    n_tests++;
    if (start_in !== 1'b0 || matrix_idx !== 2'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_gap1 got start=%b idx=%0d busy=%b want 0/1/1", start_in, matrix_idx, busy);
    end
    n_tests++;
    if (z_start_in !== 1'b1 || z_matrix_idx !== 2'd1) begin
      n_fail++;
      $display("FAIL zero_gap_start got start=%b idx=%0d want 1/1", z_start_in, z_matrix_idx);
    end
    tick; tick;                         // F+3
    n_tests++;
    if (start_in !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_gap3 got start=%b want 0", start_in);
    end
    tick;                               // F+4
    n_tests++;
    if (start_in !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_start1 got start=%b want 1", start_in);
    end
    tick;
    wait_stream(n);
    n_tests++;
    if (n !== 32) begin
      n_fail++;
      $display("FAIL basic_len1 got %0d want 32", n);
    end
    tick; tick; tick; tick;
    finish = 1'b1;
    tick;                               // F+1 after last finish
    finish = 1'b0;
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b1 || z_done !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_done got done=%b busy=%b zdone=%b want 1/1/1", done, busy, z_done);
    end
    tick;                               // F+2
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_idle got done=%b busy=%b full=%b want 0/0/1", done, busy, full);
    end
    n_tests++;
    if (exp_q.size() != 0 || zexp_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_drain got %0d/%0d left want 0/0", exp_q.size(), zexp_q.size());
    end
  endtask

  task automatic test_guards;
    do_reset;
    write_bytes(8'h80, 8'h01, 63);
    n_tests++;
    if (full !== 1'b0 || wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL guard_63 got full=%b wr_ready=%b want 0/1", full, wr_ready);
    end
    go = 1'b1;
    tick;
    go = 1'b0;
    n_tests++;
    if (start_in !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL guard_go_notfull got start=%b busy=%b want 0/0", start_in, busy);
    end
    write_bytes(8'hBF, 8'h01, 1);
    n_tests++;
    if (full !== 1'b1 || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL guard_64 got full=%b wr_ready=%b want 1/0", full, wr_ready);
    end
    wr_en = 1'b1; wr_data = 8'hEE;
    tick;
    wr_en = 1'b0;
    n_tests++;
    if (full !== 1'b1 || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL guard_65 got full=%b wr_ready=%b want 1/0", full, wr_ready);
    end
  endtask

  task automatic test_level_finish;
    int n;
    finish = 1'b1;
    push_run;
    go = 1'b1; wr_en = 1'b1; wr_data = 8'h55;   // go wins, write dropped
    tick;
    go = 1'b0; wr_en = 1'b0;
    n_tests++;
    if (start_in !== 1'b1) begin
      n_fail++;
      $display("FAIL level_start got %b want 1", start_in);
    end
    tick;
    wait_stream(n);
    n_tests++;
    if (n !== 32) begin
      n_fail++;
      $display("FAIL level_len0 got %0d want 32", n);
    end
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if ({start_in, valid_input, matrix_idx} !== 4'b0 || z_start_in !== 1'b0) begin
        n_fail++;
        $display("FAIL level_hold0 got start=%b valid=%b idx=%0d zstart=%b want 0/0/0/0",
                 start_in, valid_input, matrix_idx, z_start_in);
      end
      tick;
    end
    finish = 1'b0;
    tick;
    finish = 1'b1;
    tick;                               // F+1, finish stays high
    n_tests++;
    if (z_start_in !== 1'b1 || matrix_idx !== 2'd1 || start_in !== 1'b0) begin
      n_fail++;
      $display("FAIL level_edge got zstart=%b idx=%0d start=%b want 1/1/0", z_start_in, matrix_idx, start_in);
    end
    tick; tick; tick;                   // F+4
    n_tests++;
    if (start_in !== 1'b1) begin
      n_fail++;
      $display("FAIL level_start1 got %b want 1", start_in);
    end
    tick;
    wait_stream(n);
    n_tests++;
    if (n !== 32) begin
      n_fail++;
      $display("FAIL level_len1 got %0d want 32", n);
    end
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b1 || z_done !== 1'b0) begin
        n_fail++;
        $display("FAIL level_hold1 got done=%b busy=%b zdone=%b want 0/1/0", done, busy, z_done);
      end
      tick;
    end
    finish = 1'b0;
    tick;
    finish = 1'b1;
    tick;
    finish = 1'b0;
    n_tests++;
    if (done !== 1'b1 || z_done !== 1'b1) begin
      n_fail++;
      $display("FAIL level_done got done=%b zdone=%b want 1/1", done, z_done);
    end
    tick;
    n_tests++;
    if (busy !== 1'b0 || exp_q.size() != 0 || zexp_q.size() != 0) begin
      n_fail++;
      $display("FAIL level_end got busy=%b left=%0d/%0d want 0/0/0", busy, exp_q.size(), zexp_q.size());
    end
  endtask

  task automatic test_ignore;
    int n;
    push_run;
    go = 1'b1;
    tick;
    go = 1'b0;
    clr = 1'b1; wr_en = 1'b1; wr_data = 8'hAA;
    tick;
    clr = 1'b0; wr_en = 1'b0;
    n_tests++;
    if (full !== 1'b1 || valid_input !== 1'b1) begin
      n_fail++;
      $display("FAIL ignore_busy got full=%b valid=%b want 1/1", full, valid_input);
    end
    wait_stream(n);
    n_tests++;
    if (n !== 32) begin
      n_fail++;
      $display("FAIL ignore_len0 got %0d want 32", n);
    end
    finish = 1'b1;
    tick;
    finish = 1'b0;
    tick; tick; tick;
    n_tests++;
    if (start_in !== 1'b1) begin
      n_fail++;
      $display("FAIL ignore_start1 got %b want 1", start_in);
    end
    tick;
    wait_stream(n);
    finish = 1'b1;
    tick;
    finish = 1'b0;
    n_tests++;
    if (done !== 1'b1 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL ignore_done got done=%b full=%b want 1/1", done, full);
    end
    tick;
    n_tests++;
    if (exp_q.size() != 0 || zexp_q.size() != 0) begin
      n_fail++;
      $display("FAIL ignore_drain got %0d/%0d left want 0/0", exp_q.size(), zexp_q.size());
    end
    clr = 1'b1; go = 1'b1;              // clr beats go
    tick;
    clr = 1'b0; go = 1'b0;
    tick;
    n_tests++;
    if (start_in !== 1'b0 || busy !== 1'b0 || full !== 1'b0 || wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_go got start=%b busy=%b full=%b wr_ready=%b want 0/0/0/1",
               start_in, busy, full, wr_ready);
    end
    clr = 1'b1; wr_en = 1'b1; wr_data = 8'h11; // clear wins, write dropped
    tick;
    clr = 1'b0; wr_en = 1'b0;
    m_wptr = 0;
    write_bytes(8'h40, 8'h01, 63);
    n_tests++;
    if (full !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_wr_63 got full=%b want 0", full);
    end
    write_bytes(8'h7F, 8'h01, 1);
    n_tests++;
    if (full !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_wr_64 got full=%b want 1", full);
    end
  endtask

  task automatic test_mid_reset;
    do_reset;
    write_bytes(8'h00, 8'h03, 64);
    for (int i = 0; i <= 10; i++) begin
      exp_q.push_back(model[i]);
      zexp_q.push_back(model[i]);
    end
    go = 1'b1;
    tick;
    go = 1'b0;
    tick;                               // byte 0
    for (int i = 0; i < 10; i++) tick;  // byte 10
    n_tests++;
    if (valid_input !== 1'b1 || X_load !== 8'd30) begin
      n_fail++;
      $display("FAIL midrst_byte10 got valid=%b X_load=%02h want 1/1e", valid_input, X_load);
    end
    rst = 1'b0;
    tick;
    rst = 1'b1;
    n_tests++;
    if ({valid_input, start_in, busy, full} !== 4'b0 || X_load !== 8'h00 || z_valid_input !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_out got valid=%b start=%b busy=%b full=%b X_load=%02h want 0/0/0/0/00",
               valid_input, start_in, busy, full, X_load);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_nodone got done=%b busy=%b want 0/0", done, busy);
      end
      tick;
    end
    m_wptr = 0;
    write_bytes(8'h00, 8'h01, 63);
    n_tests++;
    if (full !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_wptr got full=%b want 0", full);
    end
    write_bytes(8'h3F, 8'h01, 1);
    n_tests++;
    if (full !== 1'b1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL midrst_refill got full=%b left=%0d want 1/0", full, exp_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_guards;
    test_level_finish;
    test_ignore;
    test_mid_reset;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
